// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
//
// Write-domain pointer and flag controller for an asynchronous FIFO. It owns
// the write pointer (binary and gray) and decides, from the read pointer
// already synchronised into clk_in, whether the FIFO is full, almost full,
// how many entries are occupied, and whether a write was ever refused.
//
// Producer handshake:
//   winc is the producer's write request. A write is accepted in a cycle
//   exactly when wen is high (winc & ~full & ~flush). The producer must keep
//   winc and its data stable until it sees wen high at a clk_in edge. A
//   request made while full is refused and latches the sticky overflow flag.
//   A request made during flush is dropped and does not count as overflow.
//
// Parameters:
//   depth      address bits; the FIFO holds 2**depth entries and the
//              pointers are depth+1 bits wide (extra wrap bit)
//   AF_THRESH  almost_full threshold, 1..2**depth entries
//
// Ports:
//   clk_in       in   write-domain clock
//   reset        in   asynchronous, active-high reset
//   flush        in   synchronous clear of all write-side state
//   winc         in   write request from producer
//   r2wsync_ff2  in   gray read pointer, synchronised to clk_in
//   wen          out  RAM write enable (combinational)
//   waddr        out  RAM write address, low depth bits of the binary pointer
//   wptr         out  registered gray write pointer (to the wr->rd synchroniser)
//   full         out  registered full flag
//   almost_full  out  registered, fill level >= AF_THRESH
//   wlevel       out  registered fill level seen from the write side
//   overflow     out  sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module wptr_full_ctrl #(
    parameter int depth     = 7,
    parameter int AF_THRESH = 120
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             flush,
    input  logic             winc,
    input  logic [depth:0]   r2wsync_ff2,
    output logic             wen,
    output logic [depth-1:0] waddr,
    output logic [depth:0]   wptr,
    output logic             full,
    output logic             almost_full,
    output logic [depth:0]   wlevel,
    output logic             overflow
);

    // Threshold narrowed to the level width; 2**depth still fits in depth+1 bits.
    localparam logic [depth:0] AF_LVL = (depth+1)'(AF_THRESH);

    logic [depth:0] wbin;        // binary write pointer
    logic [depth:0] wbin_next;
    logic [depth:0] wgray_next;
    logic [depth:0] rbin;        // synchronised read pointer, back in binary
    logic [depth:0] full_tgt;    // gray value wptr would hold when exactly full
    logic [depth:0] level_next;
    logic           full_next;
    logic           af_next;

    // A write is taken only when there is room and no flush is in progress.
    assign wen   = winc & ~full & ~flush;
    assign waddr = wbin[depth-1:0];

    // Pointer advance wraps naturally through all 2**(depth+1) codes.
    assign wbin_next  = wbin + {{depth{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= depth; i++) begin
            rbin[i] = ^(r2wsync_ff2 >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    // In gray code that means the top two bits are inverted and the rest equal.
    generate
        if (depth == 1) begin : g_full_tgt_d1
            assign full_tgt = ~r2wsync_ff2;
        end else begin : g_full_tgt
            assign full_tgt = {~r2wsync_ff2[depth:depth-1], r2wsync_ff2[depth-2:0]};
        end
    endgenerate

    // Level is computed against the possibly stale read pointer, so it can only
    // over-report occupancy; full and level fall only when the read pointer moves.
    assign level_next = wbin_next - rbin;
    assign full_next  = (wgray_next == full_tgt);
    assign af_next    = (level_next >= AF_LVL);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wbin        <= '0;
            wptr        <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else if (flush) begin
            // Held cleared for as long as flush stays high.
            wbin        <= '0;
            wptr        <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            wlevel      <= level_next;
            full        <= full_next;
            almost_full <= af_next;
            // Refused request: pointer is untouched, the error is remembered.
            if (winc && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
//
// Directed bench for wptr_full_ctrl at depth=3 (8 entries), AF_THRESH=6.
// Each step drives inputs just after a rising edge and queues the outputs
// expected at the following falling edge: the registered outputs produced by
// the edge that opened the step, and wen for the inputs just applied.
// A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_wptr_full_ctrl;

    localparam int DEPTH = 3;
    localparam int AF    = 6;
    localparam int W     = 15;  // wen, waddr[3], wptr[4], full, af, wlevel[4], ovf

    logic             clk_in;
    logic             reset;
    logic             flush;
    logic             winc;
    logic [DEPTH:0]   r2wsync_ff2;
    logic             wen;
    logic [DEPTH-1:0] waddr;
    logic [DEPTH:0]   wptr;
    logic             full;
    logic             almost_full;
    logic [DEPTH:0]   wlevel;
    logic             overflow;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    wptr_full_ctrl #(
        .depth     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .flush       (flush),
        .winc        (winc),
        .r2wsync_ff2 (r2wsync_ff2),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        winc        = 1'b0;
        r2wsync_ff2 = '0;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pack(input logic p_wen, input logic [2:0] p_waddr,
                                          input logic [3:0] p_wptr, input logic p_full,
                                          input logic p_af, input logic [3:0] p_lvl,
                                          input logic p_ovf);
        return {p_wen, p_waddr, p_wptr, p_full, p_af, p_lvl, p_ovf};
    endfunction

    // Drive one step and queue the outputs expected at the next falling edge.
    task automatic step(input logic rst_v, input logic fl_v, input logic wi_v,
                        input logic [3:0] rg_v,
                        input logic e_wen, input logic [2:0] e_waddr, input logic [3:0] e_wptr,
                        input logic e_full, input logic e_af, input logic [3:0] e_lvl,
                        input logic e_ovf);
        @(posedge clk_in);
        #1;
        reset       = rst_v;
        flush       = fl_v;
        winc        = wi_v;
        r2wsync_ff2 = rg_v;
        exp_q.push_back(pack(e_wen, e_waddr, e_wptr, e_full, e_af, e_lvl, e_ovf));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_in) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = pack(wen, waddr, wptr, full, almost_full, wlevel, overflow);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL step%0d: got wen=%b waddr=%0d wptr=%0d full=%b af=%b lvl=%0d ovf=%b, expected wen=%b waddr=%0d wptr=%0d full=%b af=%b lvl=%0d ovf=%b",
                         step_no, a[14], a[13:11], a[10:7], a[6], a[5], a[4:1], a[0],
                         e[14], e[13:11], e[10:7], e[6], e[5], e[4:1], e[0]);
            end
            step_no++;
        end
    end

    // ---------------- directed vectors ----------------
    //            rst fl wi rg      wen addr wptr full af lvl ovf
    initial begin
        // reset held, then released: everything stays at zero
        step(1, 0, 0, 4'd0,     0, 3'd0, 4'd0,  0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0,     0, 3'd0, 4'd0,  0, 0, 4'd0, 0);
        // eight back-to-back writes with the read pointer parked at 0
        step(0, 0, 1, 4'd0,     1, 3'd0, 4'd0,  0, 0, 4'd0, 0);
        step(0, 0, 1, 4'd0,     1, 3'd1, 4'd1,  0, 0, 4'd1, 0);
        step(0, 0, 1, 4'd0,     1, 3'd2, 4'd3,  0, 0, 4'd2, 0);
        step(0, 0, 1, 4'd0,     1, 3'd3, 4'd2,  0, 0, 4'd3, 0);
        step(0, 0, 1, 4'd0,     1, 3'd4, 4'd6,  0, 0, 4'd4, 0);
        step(0, 0, 1, 4'd0,     1, 3'd5, 4'd7,  0, 0, 4'd5, 0);
        step(0, 0, 1, 4'd0,     1, 3'd6, 4'd5,  0, 1, 4'd6, 0);
        step(0, 0, 1, 4'd0,     1, 3'd7, 4'd4,  0, 1, 4'd7, 0);  // last free slot
        // full: further writes refused, overflow latches and sticks
        step(0, 0, 1, 4'd0,     0, 3'd0, 4'd12, 1, 1, 4'd8, 0);
        step(0, 0, 0, 4'd0,     0, 3'd0, 4'd12, 1, 1, 4'd8, 1);
        step(0, 0, 0, 4'd0,     0, 3'd0, 4'd12, 1, 1, 4'd8, 1);
        // reads arrive: gray read pointer 0 -> 1 -> 3
        step(0, 0, 0, 4'd1,     0, 3'd0, 4'd12, 1, 1, 4'd8, 1);
        step(0, 0, 0, 4'd3,     0, 3'd0, 4'd12, 0, 1, 4'd7, 1);
        step(0, 0, 0, 4'd3,     0, 3'd0, 4'd12, 0, 1, 4'd6, 1);
        // wrap: write every cycle while reads trail six entries behind
        step(0, 0, 1, 4'd2,     1, 3'd0, 4'd12, 0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd6,     1, 3'd1, 4'd13, 0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd7,     1, 3'd2, 4'd15, 0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd5,     1, 3'd3, 4'd14, 0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd4,     1, 3'd4, 4'd10, 0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd12,    1, 3'd5, 4'd11, 0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd13,    1, 3'd6, 4'd9,  0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd15,    1, 3'd7, 4'd8,  0, 1, 4'd6, 1);
        step(0, 0, 1, 4'd14,    1, 3'd0, 4'd0,  0, 1, 4'd6, 1);  // wbin 15 -> 0
        step(0, 0, 1, 4'd10,    1, 3'd1, 4'd1,  0, 1, 4'd6, 1);
        // stop writing, one more read drops below the threshold
        step(0, 0, 0, 4'd10,    0, 3'd2, 4'd3,  0, 1, 4'd6, 1);
        step(0, 0, 0, 4'd11,    0, 3'd2, 4'd3,  0, 1, 4'd6, 1);
        step(0, 0, 0, 4'd11,    0, 3'd2, 4'd3,  0, 0, 4'd5, 1);
        // flush together with a write request: no write, no overflow, all cleared
        step(0, 1, 1, 4'd11,    0, 3'd2, 4'd3,  0, 0, 4'd5, 1);
        step(0, 0, 0, 4'd0,     0, 3'd0, 4'd0,  0, 0, 4'd0, 0);
        step(0, 0, 1, 4'd0,     1, 3'd0, 4'd0,  0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0,     0, 3'd1, 4'd1,  0, 0, 4'd1, 0);
        // reset pulse mid-stream clears outputs without waiting for an edge
        step(0, 0, 1, 4'd0,     1, 3'd1, 4'd1,  0, 0, 4'd1, 0);
        step(1, 0, 0, 4'd0,     0, 3'd0, 4'd0,  0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0,     0, 3'd0, 4'd0,  0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0,     0, 3'd0, 4'd0,  0, 0, 4'd0, 0);

        // let the monitor drain the queue, within a bounded number of cycles
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            @(posedge clk_in);
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
